// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller and its stream reader:
// skid occupancy encoding and default geometry.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-slot data store for the stream reader. Slot0 is the head word;
// slot1 only ever feeds slot0 through a shift.
module skid_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load0,
    input  logic                  i_load1,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_slot0
);

    logic [DATA_WIDTH-1:0] r_slot0;
    logic [DATA_WIDTH-1:0] r_slot1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            if (i_load0) begin
                r_slot0 <= i_din;
            end else if (i_shift) begin
                r_slot0 <= r_slot1;
            end
            if (i_load1) begin
                r_slot1 <= i_din;
            end
        end
    end

    assign o_slot0 = r_slot0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FWFT FIFO into a registered valid/ready stream via a 2-entry skid.
// Optional handshake counter `words_out` is built when FIFO_RD_CNT_EN is defined.
//
//  state | meaning
//  OCC_0 | buffer empty
//  OCC_1 | one word, in slot0
//  OCC_2 | two words, slot0 then slot1
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occ
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]           words_out
`endif
);

    generate
        if (ADDR_WIDTH < 1) begin : g_bad_addr_width
            $error("fifo_stream_reader: ADDR_WIDTH must be at least 1");
        end
    endgenerate

    occ_e r_occ;
    occ_e w_occ_nxt;
    logic w_pop;
    logic w_out;
    logic w_load0;
    logic w_load1;
    logic w_shift;

    // Pop depends only on local state and FIFO flags, never on m_ready.
    assign w_pop   = en & ~flush & ~fifo_empty & (r_occ != OCC_2);
    assign w_out   = m_valid & m_ready;
    assign fifo_rd = w_pop;
    assign m_valid = (r_occ != OCC_0);
    assign occ     = r_occ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ <= OCC_0;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        w_load0   = 1'b0;
        w_load1   = 1'b0;
        w_shift   = 1'b0;
        if (flush) begin
            w_occ_nxt = OCC_0;
        end else begin
            case (r_occ)
                OCC_0: begin
                    if (w_pop) begin
                        w_occ_nxt = OCC_1;
                        w_load0   = 1'b1;
                    end
                end
                OCC_1: begin
                    if (w_pop && w_out) begin
                        w_load0 = 1'b1;
                    end else if (w_pop) begin
                        w_occ_nxt = OCC_2;
                        w_load1   = 1'b1;
                    end else if (w_out) begin
                        w_occ_nxt = OCC_0;
                    end
                end
                OCC_2: begin
                    if (w_out) begin
                        w_occ_nxt = OCC_1;
                        w_shift   = 1'b1;
                    end
                end
                default: begin
                    w_occ_nxt = OCC_0;
                end
            endcase
        end
    end

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .i_load0 (w_load0),
        .i_load1 (w_load1),
        .i_shift (w_shift),
        .i_din   (fifo_rdata),
        .o_slot0 (m_data)
    );

`ifdef FIFO_RD_CNT_EN
    logic [15:0] r_words_out;

    // Handshakes during a flush cycle still count as delivered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_words_out <= 16'd0;
        end else if (w_out) begin
            r_words_out <= r_words_out + 16'd1;
        end
    end

    assign words_out = r_words_out;
`endif

endmodule
